// File: rtl/myproject_sdiv_pkg.sv
// rtl/myproject_sdiv_pkg.sv - shared state encoding, counter sizing and latency helper for the signed divider
package myproject_sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } sdiv_state_e;

  localparam int SDIV_DIVIDEND_WIDTH = 17;
  localparam int SDIV_DIVISOR_WIDTH  = 7;
  localparam int SDIV_CNT_W          = $clog2(SDIV_DIVIDEND_WIDTH + 1);

  // Edges from operand acceptance to out_valid; short_path covers zero divisor and early-out cases.
  function automatic int sdiv_latency(input int dividend_width, input bit short_path);
    return short_path ? 1 : dividend_width + 1;
  endfunction

endpackage

// File: rtl/myproject_sdiv_step.sv
// rtl/myproject_sdiv_step.sv - one combinational restoring-division iteration on unsigned magnitudes
module myproject_sdiv_step #(
  parameter int DIVISOR_WIDTH = 7
) (
  input  logic [DIVISOR_WIDTH:0]   rem_i,
  input  logic                     bit_i,
  input  logic [DIVISOR_WIDTH-1:0] dvs_i,
  output logic [DIVISOR_WIDTH:0]   rem_o,
  output logic                     q_o
);

  logic [DIVISOR_WIDTH+1:0] shifted;
  logic [DIVISOR_WIDTH+1:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, dvs_i};
    // A set top bit means the trial subtraction went negative: restore.
    q_o     = ~diff[DIVISOR_WIDTH+1];
    rem_o   = q_o ? diff[DIVISOR_WIDTH:0] : shifted[DIVISOR_WIDTH:0];
  end

endmodule

// File: rtl/myproject_sdiv_17s_7s_seq.sv
// rtl/myproject_sdiv_17s_7s_seq.sv - sequential signed restoring divider, C truncating semantics
// MYPROJECT_SDIV_EARLY_OUT_EN: zero dividend or unit divisor bypasses the iteration loop.
module myproject_sdiv_17s_7s_seq
  import myproject_sdiv_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = SDIV_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = SDIV_DIVISOR_WIDTH
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int N     = DIVIDEND_WIDTH;
  localparam int M     = DIVISOR_WIDTH;
  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  sdiv_state_e    state_q, state_d;
  logic [N-1:0]   mag_q, mag_d;  // dividend magnitude shifts out MSB-first, quotient bits shift in
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M:0]     rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           dbz_q, dbz_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [M-1:0]   remainder_q, remainder_d;

  logic [N-1:0]   dividend_abs;
  logic [M-1:0]   divisor_abs;
  logic           divisor_zero;
  logic           ovf_det;
  logic           early_out;
  logic [M:0]     step_rem;
  logic           step_q;
  logic           unused_id;

  assign unused_id    = ^ID;
  assign dividend_abs = dividend[N-1] ? (~dividend + N'(1)) : dividend;
  assign divisor_abs  = divisor[M-1] ? (~divisor + M'(1)) : divisor;
  assign divisor_zero = (divisor == '0);
  assign ovf_det      = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);

`ifdef MYPROJECT_SDIV_EARLY_OUT_EN
  assign early_out = (dividend == '0) || (divisor_abs == M'(1));
`else
  assign early_out = 1'b0;
`endif

  myproject_sdiv_step #(
    .DIVISOR_WIDTH(M)
  ) u_step (
    .rem_i(rem_q),
    .bit_i(mag_q[N-1]),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = dividend_abs;
          dvs_d   = divisor_abs;
          qneg_d  = dividend[N-1] ^ divisor[M-1];
          rneg_d  = dividend[N-1];
          dbz_d   = divisor_zero;
          ovf_d   = ovf_det;
          cnt_d   = '0;
          // Zero divisor reports the raw low dividend bits as remainder.
          rem_d   = divisor_zero ? {1'b0, dividend[M-1:0]} : '0;
          state_d = (divisor_zero || early_out) ? FIXUP : CALC;
        end
      end
      CALC: begin
        mag_d = {mag_q[N-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (dbz_q) begin
          quotient_d  = '1;
          remainder_d = rem_q[M-1:0];
        end else begin
          quotient_d  = qneg_q ? (~mag_q + N'(1)) : mag_q;
          remainder_d = rneg_q ? (~rem_q[M-1:0] + M'(1)) : rem_q[M-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = out_valid & dbz_q;
  assign overflow    = out_valid & ovf_q;

endmodule

// File: tb/tb_myproject_sdiv_17s_7s_seq.sv
// tb/tb_myproject_sdiv_17s_7s_seq.sv - scoreboard bench for the sequential signed divider
module tb_myproject_sdiv_17s_7s_seq;
  import myproject_sdiv_pkg::*;

  localparam int N = 17;
  localparam int M = 7;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 ap_clk = ~ap_clk;

  myproject_sdiv_17s_7s_seq #(
    .ID(1), .DIVIDEND_WIDTH(N), .DIVISOR_WIDTH(M)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    bit   short_path;
    int   qi;
    int   ri;
    short_path = (b == 0);
`ifdef MYPROJECT_SDIV_EARLY_OUT_EN
    if (a == 0 || b == 1 || b == -1) short_path = 1'b1;
`endif
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.q   = '1;
      e.r   = a[M-1:0];
      e.dbz = 1'b1;
    end else if (a == -65536 && b == -1) begin
      e.q   = 17'h10000;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      qi  = a / b;
      ri  = a % b;
      e.q = qi[N-1:0];
      e.r = ri[M-1:0];
    end
    e.lat = sdiv_latency(N, short_path);
    return e;
  endfunction

  task automatic run_op(input int a, input int b, input int stall, input bit poke);
    exp_t e;
    int   lat;
    sb.push_back(model(a, b));
    @(negedge ap_clk);
    dividend = a[N-1:0];
    divisor  = b[M-1:0];
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge ap_clk);
      lat++;
      #1;
    end
    e = sb.pop_front();
    check("latency", lat, e.lat);
    if (!out_valid) begin
      ap_rst_n = 1'b0;
      #2 ap_rst_n = 1'b1;
      return;
    end
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = 1'b1;
        dividend = N'($urandom);
        divisor  = M'($urandom);
      end
      check("stall_quotient", 32'(quotient), 32'(e.q));
      check("stall_remainder", 32'(remainder), 32'(e.r));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge ap_clk);
      #1;
    end
    in_valid = 1'b0;
    check("out_valid", 32'(out_valid), 32'd1);
    check("quotient", 32'(quotient), 32'(e.q));
    check("remainder", 32'(remainder), 32'(e.r));
    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    check("overflow", 32'(overflow), 32'(e.ovf));
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1 out_ready = 1'b0;
    check("out_valid_cleared", 32'(out_valid), 32'd0);
    check("flags_cleared", 32'({div_by_zero, overflow}), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    if (poke) begin
      @(posedge ap_clk);
      #1 check("poke_not_accepted", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int a;
    int b;
    int seen;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;

    run_op(100, 7, 0, 1'b0);
    run_op(-100, 7, 0, 1'b0);
    run_op(100, -7, 0, 1'b0);
    run_op(-100, -7, 0, 1'b0);
    run_op(12345, 0, 0, 1'b0);
    run_op(-65536, -1, 0, 1'b0);
    run_op(0, 5, 0, 1'b0);
    run_op(77, -1, 0, 1'b0);
    run_op(65535, -64, 1, 1'b0);
    run_op(-65536, 63, 0, 1'b0);
    run_op(-65536, -64, 0, 1'b0);
    run_op(-1, 0, 0, 1'b0);
    run_op(1000, 3, 5, 1'b1);

    // Abort an operation mid-iteration with reset.
    @(negedge ap_clk);
    dividend = 17'd4321;
    divisor  = 7'd9;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge ap_clk);
    #1 check("calc_in_ready", 32'(in_ready), 32'd0);
    ap_rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge ap_clk);
      #1 if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, 131071)) - 65536;
      case ($urandom_range(0, 9))
        0:       b = 0;
        1:       b = -1;
        2:       b = -64;
        default: b = int'($urandom_range(0, 127)) - 64;
      endcase
      if ($urandom_range(0, 19) == 0) a = -65536;
      run_op(a, b, int'($urandom_range(0, 3)), 1'b0);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
